// File: rtl/mp_add_pkg.sv
// Shared types and helpers for the nibble-serial adder/subtractor mp_add_seq.
package mp_add_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Width of the slice counter for an operand of the given width (at least 1 bit).
    function automatic int cnt_w(input int width);
        int n;
        int w;
        n = width / SLICE_W;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/cla4_slice.sv
// Combinational 4-bit carry-lookahead adder slice; c3 is the carry into bit 3.
module cla4_slice (
    input  logic [3:0] a4,
    input  logic [3:0] b4,
    input  logic       ci,
    output logic [3:0] s4,
    output logic       co,
    output logic       c3
);

    logic [3:0] p;
    logic [3:0] g;
    logic       c1;
    logic       c2;

    always_comb begin
        p  = a4 ^ b4;
        g  = a4 & b4;
        c1 = g[0] | (p[0] & ci);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & ci);
        s4 = p ^ {c3, c2, c1, ci};
    end

endmodule

// File: rtl/mp_add_seq.sv
// Sequential multi-precision add/subtract, one 4-bit CLA slice per cycle.
// Optional signed-overflow output enabled by defining MP_ADD_SEQ_OVF_EN.
module mp_add_seq
    import mp_add_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef MP_ADD_SEQ_OVF_EN
    output logic             ovf,
`endif
    output logic             busy
);

    localparam int N     = WIDTH / SLICE_W;
    localparam int CNT_W = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [3:0]       s4;
    logic             co;
    logic             c3;

    cla4_slice u_slice (
        .a4 (a_q[SLICE_W-1:0]),
        .b4 (b_q[SLICE_W-1:0]),
        .ci (carry_q),
        .s4 (s4),
        .co (co),
        .c3 (c3)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Operands drain from the bottom; results enter at the top.
                a_d     = {{SLICE_W{1'b0}}, a_q[WIDTH-1:SLICE_W]};
                b_d     = {{SLICE_W{1'b0}}, b_q[WIDTH-1:SLICE_W]};
                sum_d   = {s4, sum_q[WIDTH-1:SLICE_W]};
                carry_d = co;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef MP_ADD_SEQ_OVF_EN
    logic ovf_q, ovf_d;

    // Updated every slice; the last slice leaves carry-into-MSB XOR carry-out.
    always_comb begin
        ovf_d = ovf_q;
        if (state_q == ST_RUN) ovf_d = c3 ^ co;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ovf_q <= 1'b0;
        else     ovf_q <= ovf_d;
    end

    assign ovf = ovf_q;
`endif

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign sum       = sum_q;
    assign cout      = carry_q;

endmodule

// File: doc/mp_add_seq.md
MP_ADD_SEQ -- requirements
Module: mp_add_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits; legal values are multiples of 4 from 8 to 64.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  an operand set is presented.
REQ-005 SHALL have port in_ready  output  1  the block can accept an operand set.
REQ-006 SHALL have ports a and b  input  WIDTH  the operands.
REQ-007 SHALL have port cin  input  1  carry-in; ignored when sub=1.
REQ-008 SHALL have port sub  input  1  selects a-b when 1, a+b+cin when 0.
REQ-009 SHALL have port out_valid  output  1  the result is valid.
REQ-010 SHALL have port out_ready  input  1  the consumer accepts the result.
REQ-011 SHALL have port sum  output  WIDTH  the result.
REQ-012 SHALL have port cout  output  1  carry out of the MSB slice.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, RUN and DONE.
REQ-015 SHALL accept an operand set on a rising edge where in_valid=1 and in_ready=1; in_ready SHALL equal 1 only in IDLE.
REQ-016 On accept, SHALL register a, b XOR {WIDTH{sub}}, and carry = (sub ? 1 : cin); SHALL clear the slice counter and move to RUN.
REQ-017 In RUN, each cycle SHALL add the low 4 bits of the a and b registers plus the carry register through one 4-bit carry-lookahead slice.
REQ-018 Each RUN cycle SHALL shift the a and b registers right by 4, insert the slice sum at the top of the sum shift register, store the slice carry-out, and increment the counter.
REQ-019 SHALL leave RUN after N = WIDTH/4 cycles and enter DONE; out_valid SHALL rise exactly N clock edges after the accepting edge (N=4 for WIDTH=16).
REQ-020 In DONE, out_valid=1 and sum/cout SHALL hold stable until a rising edge with out_ready=1, then return to IDLE.
REQ-021 The cycle after a result handshake SHALL have in_ready=1; there is no overlap of operations (throughput is one result per N+2 cycles minimum).
REQ-022 Inputs a, b, cin and sub SHALL be ignored outside the accepting edge.
REQ-023 In sub mode, cout SHALL be the raw carry (1 = no borrow), and sum SHALL be (a-b) mod 2^WIDTH.
REQ-024 out_ready asserted outside DONE SHALL have no effect.

Reset
REQ-025 rst=1 SHALL immediately force state IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, counter=0, and carry=0.
REQ-026 A reset asserted in RUN or DONE SHALL discard the operation; no out_valid SHALL appear for it after reset release.

Configuration
REQ-027 With macro MP_ADD_SEQ_OVF_EN defined, SHALL add port ovf  output  1: signed overflow, computed as the carry into the MSB XOR cout, valid with out_valid and reset to 0.
REQ-028 Without MP_ADD_SEQ_OVF_EN, the ovf port and its logic SHALL be absent.

Structure
REQ-029 Package mp_add_pkg SHALL hold the state enum type, SLICE_W=4, and the counter-width function.
REQ-030 Sub-module cla4_slice SHALL be the only sub-module: a combinational 4-bit carry-lookahead add with inputs (a4, b4, ci) and outputs (s4, co, c3), where c3 is the carry into bit 3 for overflow.

Verification (WIDTH=16)
REQ-031 a=0xFFFF, b=0x0001, cin=0, sub=0 -> sum=0x0000, cout=1; out_valid rises 4 edges after accept.
REQ-032 a=0x1234, b=0x4321, cin=1, sub=0 -> sum=0x5556, cout=0.
REQ-033 a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0; a=0x0007, b=0x0005, sub=1 -> sum=0x0002, cout=1.
REQ-034 Hold out_ready=0 for 3 cycles in DONE -> out_valid and sum stable; in_ready=0 throughout; in_valid pulses are ignored.
REQ-035 Assert rst on the 2nd RUN cycle -> all outputs match reset values at once; the next transaction 0x0001+0x0001 gives sum=0x0002.
REQ-036 With MP_ADD_SEQ_OVF_EN: a=0x7FFF, b=0x0001, sub=0 -> ovf=1, sum=0x8000; a=0x8000, b=0x0001, sub=1 -> ovf=1.
